maxpool_stream: RTL and testbench

Streaming, parametrised 1-D max-pooling stage for the ECG CNN datapath. It sits between a convolution/activation stage and the next layer. It consumes channel-interleaved samples over a valid/ready handshake and reduces every POOL consecutive time samples per channel to their maximum, using non-overlapping windows. Each result is emitted on a registered output with backpressure. A partial window at end of record is flushed on `in_last`.

---
 rtl/maxpool_stream.sv | 110 +++++++++++
 tb/tb_maxpool_stream.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming non-overlapping 1-D max-pool over CH channel-interleaved samples, registered output.
// Define MAXPOOL_ARGMAX_EN to add per-channel argmax tracking and the out_idx port.
module maxpool_stream #(
    parameter int DATA_W = 8,
    parameter int POOL   = 5,
    parameter int CH     = 1,
    parameter int SIGNED = 0,
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1,
    localparam int PW    = (POOL > 1) ? $clog2(POOL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_ch,
    output logic              out_last
`ifdef MAXPOOL_ARGMAX_EN
    ,
    output logic [PW-1:0]     out_idx
`endif
);

    logic [CW-1:0]     ch_cnt;
    logic [PW-1:0]     smp_cnt;
    logic [DATA_W-1:0] max_r [CH];
    logic              accept;
    logic              first;
    logic              ch_wrap;
    logic              complete;
    logic              take;
    logic [DATA_W-1:0] cur_max;
    logic [DATA_W-1:0] new_max;

    function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign first    = (smp_cnt == '0);
    assign ch_wrap  = (ch_cnt == CW'(CH - 1));
    assign complete = (smp_cnt == PW'(POOL - 1)) || in_last;
    assign cur_max  = max_r[ch_cnt];
    // Strict greater-than keeps the earliest sample on ties; sample 0 always loads.
    assign take     = first || gt(in_data, cur_max);
    assign new_max  = take ? in_data : cur_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt  <= '0;
            smp_cnt <= '0;
        end else if (accept) begin
            if (ch_wrap) begin
                ch_cnt  <= '0;
                smp_cnt <= complete ? '0 : smp_cnt + 1'b1;
            end else begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) max_r[i] <= '0;
        end else if (accept) begin
            max_r[ch_cnt] <= new_max;
        end
    end

    // A completing beat may reload the register in the same cycle the old result leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else if (accept && complete) begin
            out_valid <= 1'b1;
            out_data  <= new_max;
            out_ch    <= ch_cnt;
            out_last  <= in_last && ch_wrap;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MAXPOOL_ARGMAX_EN
    logic [PW-1:0] idx_r [CH];
    logic [PW-1:0] new_idx;

    assign new_idx = take ? smp_cnt : idx_r[ch_cnt];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) idx_r[i] <= '0;
            out_idx <= '0;
        end else if (accept) begin
            idx_r[ch_cnt] <= new_idx;
            if (complete) out_idx <= new_idx;
        end
    end
`endif

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench for maxpool_stream: unsigned/signed POOL=5 CH=1 pair on a shared stream,
// plus a POOL=2 CH=2 instance for channel interleaving. Argmax checked when MAXPOOL_ARGMAX_EN.
module tb_maxpool_stream;

    typedef struct {
        logic [7:0] data;
        logic [2:0] idx;
        logic       last;
        logic       ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic hold = 1'b1;

    exp_t q_u[$];
    exp_t q_s[$];
    exp_t q_c[$];

    // Shared stream for the POOL=5 CH=1 pair
    logic       a_valid = 1'b0, a_last = 1'b0, a_oready = 1'b1;
    logic [7:0] a_data = '0;
    logic       u_ready, u_valid, u_last, s_ready, s_valid, s_last;
    logic [7:0] u_data, s_data;
    logic [0:0] u_ch, s_ch;
    logic [2:0] u_idx, s_idx;

    // Stream for the POOL=2 CH=2 instance
    logic       c_valid = 1'b0, c_last = 1'b0, c_oready = 1'b1;
    logic [7:0] c_data = '0;
    logic       k_ready, k_valid, k_last;
    logic [7:0] k_data;
    logic [0:0] k_ch, k_idx;

    maxpool_stream #(.DATA_W(8), .POOL(5), .CH(1), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(u_ready), .in_data(a_data),
        .in_last(a_last), .out_valid(u_valid), .out_ready(a_oready), .out_data(u_data),
        .out_ch(u_ch), .out_last(u_last)
`ifdef MAXPOOL_ARGMAX_EN
        , .out_idx(u_idx)
`endif
    );

    maxpool_stream #(.DATA_W(8), .POOL(5), .CH(1), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(s_ready), .in_data(a_data),
        .in_last(a_last), .out_valid(s_valid), .out_ready(a_oready), .out_data(s_data),
        .out_ch(s_ch), .out_last(s_last)
`ifdef MAXPOOL_ARGMAX_EN
        , .out_idx(s_idx)
`endif
    );

    maxpool_stream #(.DATA_W(8), .POOL(2), .CH(2), .SIGNED(0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(k_ready), .in_data(c_data),
        .in_last(c_last), .out_valid(k_valid), .out_ready(c_oready), .out_data(k_data),
        .out_ch(k_ch), .out_last(k_last)
`ifdef MAXPOOL_ARGMAX_EN
        , .out_idx(k_idx[0])
`endif
    );

`ifndef MAXPOOL_ARGMAX_EN
    assign u_idx = '0;
    assign s_idx = '0;
    assign k_idx = '0;
`endif

    // Reference model state
    int         ma_cnt = 0;
    logic [7:0] mu = '0, ms = '0;
    logic [2:0] iu = '0, isg = '0;
    int         mc_ch = 0, mc_smp = 0;
    logic [7:0] mc_max [2];
    logic [2:0] mc_idx [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e, input logic [7:0] d,
                             input logic [2:0] idx, input logic last, input logic ch);
        check({tag, "_data"}, 32'(d), 32'(e.data));
        check({tag, "_last"}, 32'(last), 32'(e.last));
        check({tag, "_ch"}, 32'(ch), 32'(e.ch));
`ifdef MAXPOOL_ARGMAX_EN
        check({tag, "_idx"}, 32'(idx), 32'(e.idx));
`endif
    endtask

    task automatic model_a(input logic [7:0] d, input logic last);
        exp_t e;
        if (ma_cnt == 0 || d > mu) begin mu = d; iu = 3'(ma_cnt); end
        if (ma_cnt == 0 || $signed(d) > $signed(ms)) begin ms = d; isg = 3'(ma_cnt); end
        if (ma_cnt == 4 || last) begin
            e.data = mu; e.idx = iu; e.last = last; e.ch = 1'b0;
            q_u.push_back(e);
            e.data = ms; e.idx = isg;
            q_s.push_back(e);
            ma_cnt = 0;
        end else begin
            ma_cnt++;
        end
    endtask

    task automatic model_c(input logic [7:0] d, input logic last);
        exp_t e;
        if (mc_smp == 0 || d > mc_max[mc_ch]) begin
            mc_max[mc_ch] = d;
            mc_idx[mc_ch] = 3'(mc_smp);
        end
        if (mc_smp == 1 || last) begin
            e.data = mc_max[mc_ch]; e.idx = mc_idx[mc_ch];
            e.last = last && (mc_ch == 1); e.ch = (mc_ch == 1);
            q_c.push_back(e);
        end
        if (mc_ch == 1) begin
            mc_ch  = 0;
            mc_smp = (mc_smp == 1 || last) ? 0 : mc_smp + 1;
        end else begin
            mc_ch = 1;
        end
    endtask

    // out_ready only ever changes just after a rising edge
    task automatic set_ready(input logic a, input logic c);
        @(posedge clk); #1;
        a_oready = a;
        c_oready = c;
    endtask

    initial forever begin
        @(posedge clk); #1;
        if (!hold) begin
            a_oready = ($urandom_range(0, 3) != 0);
            c_oready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send_a(input logic [7:0] d, input logic last);
        int t = 0;
        @(negedge clk);
        a_valid = 1'b1; a_data = d; a_last = last;
        while (!(u_ready && s_ready) && t < 64) begin @(negedge clk); t++; end
        if (t == 64) check("a_accept_timeout", 32'(u_ready && s_ready), 32'(1));
        else model_a(d, last);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic send_c(input logic [7:0] d, input logic last);
        int t = 0;
        @(negedge clk);
        c_valid = 1'b1; c_data = d; c_last = last;
        while (!k_ready && t < 64) begin @(negedge clk); t++; end
        if (t == 64) check("c_accept_timeout", 32'(k_ready), 32'(1));
        else model_c(d, last);
        @(posedge clk); #1;
        c_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_u_valid", 32'(u_valid), 32'(0));
        check("rst_u_data", 32'(u_data), 32'(0));
        check("rst_u_last", 32'(u_last), 32'(0));
        check("rst_u_ch", 32'(u_ch), 32'(0));
        check("rst_u_idx", 32'(u_idx), 32'(0));
        check("rst_s_valid", 32'(s_valid), 32'(0));
        check("rst_k_valid", 32'(k_valid), 32'(0));
        check("rst_k_data", 32'(k_data), 32'(0));
        check("rst_k_ch", 32'(k_ch), 32'(0));
        q_u.delete(); q_s.delete(); q_c.delete();
        ma_cnt = 0; mc_ch = 0; mc_smp = 0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_u_in_ready", 32'(u_ready), 32'(1));
        check("rst_k_in_ready", 32'(k_ready), 32'(1));
    endtask

    task automatic drain();
        int t = 0;
        @(posedge clk); #1;
        hold = 1'b1; a_oready = 1'b1; c_oready = 1'b1;
        while ((q_u.size() + q_s.size() + q_c.size()) != 0 && t < 50) begin
            @(posedge clk); t++;
        end
        check("drain_left", 32'(q_u.size() + q_s.size() + q_c.size()), 32'(0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("u_in_ready_rule", 32'(u_ready), 32'(!u_valid || a_oready));
            if (u_valid && a_oready) begin
                if (q_u.size() == 0) check("u_spurious", 32'(u_valid), 32'(0));
                else begin e = q_u.pop_front(); check_out("u", e, u_data, u_idx, u_last, u_ch[0]); end
            end
            if (s_valid && a_oready) begin
                if (q_s.size() == 0) check("s_spurious", 32'(s_valid), 32'(0));
                else begin e = q_s.pop_front(); check_out("s", e, s_data, s_idx, s_last, s_ch[0]); end
            end
            if (k_valid && c_oready) begin
                if (q_c.size() == 0) check("k_spurious", 32'(k_valid), 32'(0));
                else begin
                    e = q_c.pop_front();
                    check_out("k", e, k_data, {2'b00, k_idx}, k_last, k_ch[0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v1 [5] = '{8'd3, 8'd9, 8'd2, 8'd9, 8'd1};
        logic [7:0] v2 [5] = '{8'h80, 8'hFF, 8'h90, 8'hF0, 8'h85};
        logic       lst;

        do_reset();

        // Max with tie, argmax and backpressure: result must wait, in_ready low
        set_ready(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_a(v1[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(u_valid), 32'(1));
            check("bp_in_ready", 32'(u_ready), 32'(0));
            check("bp_data", 32'(u_data), 32'h09);
        end
        set_ready(1'b1, 1'b1);
        @(negedge clk); @(negedge clk);
        check("bp_cleared", 32'(u_valid), 32'(0));

        // Signed vs unsigned compare
        for (int i = 0; i < 5; i++) send_a(v2[i], 1'b0);
        // Differs by signedness: unsigned 0xF0, signed 0x05
        send_a(8'h05, 1'b0); send_a(8'hF0, 1'b0); send_a(8'h80, 1'b0);
        send_a(8'h01, 1'b0); send_a(8'h02, 1'b0);

        // Back-to-back completions via in_last: output reloads while transferring
        send_a(8'd10, 1'b1); send_a(8'd20, 1'b1); send_a(8'd30, 1'b1); send_a(8'd40, 1'b1);

        // Partial-window flush, then a fresh window
        send_a(8'd5, 1'b0); send_a(8'd8, 1'b0); send_a(8'd6, 1'b1);
        send_a(8'd2, 1'b0); send_a(8'd1, 1'b0); send_a(8'd1, 1'b0);
        send_a(8'd1, 1'b0); send_a(8'd1, 1'b0);
        drain();

        // Reset drops a pending result, then discards a partial window
        set_ready(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) send_a(8'd100, 1'b0);
        do_reset();
        set_ready(1'b1, 1'b1);
        send_a(8'd7, 1'b0); send_a(8'd200, 1'b0); send_a(8'd9, 1'b0);
        do_reset();
        for (int i = 1; i <= 5; i++) send_a(8'(i), 1'b0);
        drain();

        // Random stream for the pair
        hold = 1'b0;
        for (int i = 0; i < 80; i++) begin
            send_a(8'($urandom), $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) @(posedge clk);
        end
        drain();

        // Interleaved channels: (1,7),(4,2) then a last sample (3,9)
        send_c(8'd1, 1'b0); send_c(8'd7, 1'b0);
        send_c(8'd4, 1'b0); send_c(8'd2, 1'b0);
        send_c(8'd3, 1'b1); send_c(8'd9, 1'b1);
        drain();

        hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            lst = ($urandom_range(0, 7) == 0);
            send_c(8'($urandom), lst);
            send_c(8'($urandom), lst);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
